// File: rtl/vector_exec_stage.sv
// Execute stage and EX/WB register of the 4-lane vector encryption pipeline.
// Define VEC_ROTATE_EN to enable lane rotate-left on opcode 110 (otherwise it behaves as PASS).
module vector_exec_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic [2:0]       aluControlE,
  input  logic [3:0]       RdE,
  input  logic             regWriteE,
  input  logic             memWriteE,
  input  logic             updateCnt,
  input  logic [WIDTH-1:0] RD01E,
  input  logic [WIDTH-1:0] RD11E,
  input  logic [WIDTH-1:0] RD21E,
  input  logic [WIDTH-1:0] RD31E,
  input  logic [WIDTH-1:0] RD02E,
  input  logic [WIDTH-1:0] RD12E,
  input  logic [WIDTH-1:0] RD22E,
  input  logic [WIDTH-1:0] RD32E,
  input  logic [WIDTH-1:0] dataOp1,
  input  logic [WIDTH-1:0] dataOp2,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic [WIDTH-1:0] res3,
  output logic [WIDTH-1:0] resCount,
  output logic [3:0]       RdestW,
  output logic             regWriteWB,
  output logic             memWriteM,
  output logic             updateCount,
  output logic             zeroFlag,
  output logic [15:0]      retCount
);

  localparam int unsigned RET_W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
`ifdef VEC_ROTATE_EN
  localparam logic [2:0] OP_ROTL = 3'b110;
`endif

  // One lane of the ALU; unknown/disabled opcodes fall through to PASS.
  function automatic logic [WIDTH-1:0] lane_alu(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
`ifdef VEC_ROTATE_EN
    logic [2*WIDTH-1:0] dbl;
`endif
    logic [WIDTH-1:0] y;
    y = a;
`ifdef VEC_ROTATE_EN
    dbl = {a, a} << b[3:0];
`endif
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SHL:  y = a << b[3:0];
`ifdef VEC_ROTATE_EN
      OP_ROTL: y = dbl[2*WIDTH-1:WIDTH];
`endif
      default: y = a;
    endcase
    return y;
  endfunction

  logic [WIDTH-1:0] lane_y0, lane_y1, lane_y2, lane_y3;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] cnt_diff;
  logic             cnt_hit;
  logic             retire;

  always_comb begin
    lane_y0  = lane_alu(aluControlE, RD01E, RD02E);
    lane_y1  = lane_alu(aluControlE, RD11E, RD12E);
    lane_y2  = lane_alu(aluControlE, RD21E, RD22E);
    lane_y3  = lane_alu(aluControlE, RD31E, RD32E);
    cnt_next = dataOp2 + WIDTH'(1);
    cnt_diff = dataOp1 - cnt_next;
    cnt_hit  = (cnt_diff == '0);
    retire   = regWriteE | memWriteE | updateCnt;
  end

  // EX/WB register; a stall inserts a bubble by clearing only the enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0        <= '0;
      res1        <= '0;
      res2        <= '0;
      res3        <= '0;
      resCount    <= '0;
      RdestW      <= '0;
      regWriteWB  <= 1'b0;
      memWriteM   <= 1'b0;
      updateCount <= 1'b0;
      zeroFlag    <= 1'b0;
      retCount    <= '0;
    end else if (stop) begin
      regWriteWB  <= 1'b0;
      memWriteM   <= 1'b0;
      updateCount <= 1'b0;
    end else begin
      res0        <= lane_y0;
      res1        <= lane_y1;
      res2        <= lane_y2;
      res3        <= lane_y3;
      RdestW      <= RdE;
      regWriteWB  <= regWriteE;
      memWriteM   <= memWriteE;
      updateCount <= updateCnt;
      if (updateCnt) begin
        resCount <= cnt_next;
        zeroFlag <= cnt_hit;
      end
      if (retire) retCount <= retCount + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_vector_exec_stage.sv
// Scoreboard bench for vector_exec_stage: a reference model pushes the expected
// register contents each cycle, popped and compared after the capturing edge.
module tb_vector_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic [2:0]  op;
  logic [3:0]  rd;
  logic        rw, mw, uc;
  logic [15:0] la [4];
  logic [15:0] lb [4];
  logic [15:0] op1, op2;

  logic [15:0] res0, res1, res2, res3, resCount, retCount;
  logic [3:0]  RdestW;
  logic        regWriteWB, memWriteM, updateCount, zeroFlag;

  typedef struct packed {
    logic [15:0] r0, r1, r2, r3, cnt;
    logic [3:0]  rd;
    logic        rw, mw, uc, zf;
    logic [15:0] ret;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_exec_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stop(stop), .aluControlE(op), .RdE(rd),
    .regWriteE(rw), .memWriteE(mw), .updateCnt(uc),
    .RD01E(la[0]), .RD11E(la[1]), .RD21E(la[2]), .RD31E(la[3]),
    .RD02E(lb[0]), .RD12E(lb[1]), .RD22E(lb[2]), .RD32E(lb[3]),
    .dataOp1(op1), .dataOp2(op2),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .resCount(resCount), .RdestW(RdestW),
    .regWriteWB(regWriteWB), .memWriteM(memWriteM), .updateCount(updateCount),
    .zeroFlag(zeroFlag), .retCount(retCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (o)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a ^ b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a << b[3:0];
      3'd6: begin
        r = a;
`ifdef VEC_ROTATE_EN
        for (int k = 0; k < int'(b[3:0]); k++) r = {r[14:0], r[15]};
`endif
      end
      default: r = a;
    endcase
    return r;
  endfunction

  // Drive-time model update: push what the outputs must hold after the next edge.
  task automatic cycle();
    exp_t e;
    logic [15:0] nxt;
    if (!stop) begin
      m.r0 = alu_ref(op, la[0], lb[0]);
      m.r1 = alu_ref(op, la[1], lb[1]);
      m.r2 = alu_ref(op, la[2], lb[2]);
      m.r3 = alu_ref(op, la[3], lb[3]);
      m.rd = rd; m.rw = rw; m.mw = mw; m.uc = uc;
      if (uc) begin
        nxt   = op2 + 16'd1;
        m.cnt = nxt;
        m.zf  = (op1 == nxt);
      end
      if (rw | mw | uc) m.ret = m.ret + 16'd1;
    end else begin
      m.rw = 1'b0; m.mw = 1'b0; m.uc = 1'b0;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("res0", 32'(res0), 32'(e.r0));
      check_eq("res1", 32'(res1), 32'(e.r1));
      check_eq("res2", 32'(res2), 32'(e.r2));
      check_eq("res3", 32'(res3), 32'(e.r3));
      check_eq("resCount", 32'(resCount), 32'(e.cnt));
      check_eq("RdestW", 32'(RdestW), 32'(e.rd));
      check_eq("regWriteWB", 32'(regWriteWB), 32'(e.rw));
      check_eq("memWriteM", 32'(memWriteM), 32'(e.mw));
      check_eq("updateCount", 32'(updateCount), 32'(e.uc));
      check_eq("zeroFlag", 32'(zeroFlag), 32'(e.zf));
      check_eq("retCount", 32'(retCount), 32'(e.ret));
    end
  endtask

  task automatic set_lanes(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      la[i] = a; lb[i] = b;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {res0, res1}, 32'd0);
    check_eq(tag, {res2, res3}, 32'd0);
    check_eq(tag, {resCount, retCount}, 32'd0);
    check_eq(tag, {26'd0, RdestW, regWriteWB, memWriteM}, 32'd0);
    check_eq(tag, {30'd0, updateCount, zeroFlag}, 32'd0);
  endtask

  logic [15:0] lane_exp [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = '0;
    rst = 1'b1; stop = 1'b0; op = 3'd0; rd = 4'd0;
    rw = 1'b0; mw = 1'b0; uc = 1'b0; op1 = '0; op2 = '0;
    set_lanes(16'h0, 16'h0);
    #12;
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Lane opcodes on the documented operand pair.
    lane_exp = '{16'h1324, 16'h1144, 16'h12C4, 16'h0030, 16'h12F4, 16'h1234, 16'h1234};
    set_lanes(16'h1234, 16'h00F0);
    rw = 1'b1; rd = 4'd5;
    for (int i = 0; i < 7; i++) begin
      op = (i == 6) ? 3'd7 : 3'(i);
      cycle();
      check_eq("lane_tbl0", 32'(res0), 32'(lane_exp[i]));
      check_eq("lane_tbl3", 32'(res3), 32'(lane_exp[i]));
    end

    // Rotate (or PASS when the feature is absent).
    set_lanes(16'h8001, 16'h0004);
    op = 3'd6;
    cycle();
`ifdef VEC_ROTATE_EN
    check_eq("rotl", 32'(res2), 32'h0018);
`else
    check_eq("rotl_pass", 32'(res2), 32'h8001);
`endif

    // Counter loop to limit 3, then a non-counter instruction.
    op1 = 16'd3; uc = 1'b1; rw = 1'b0; op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      op2 = 16'(i);
      cycle();
      check_eq("cnt_val", 32'(resCount), 32'(i + 1));
      check_eq("cnt_zf", 32'(zeroFlag), (i == 2) ? 32'd1 : 32'd0);
    end
    uc = 1'b0; rw = 1'b1; op2 = 16'd9;
    cycle();
    check_eq("cnt_hold", {16'd0, resCount}, 32'd3);
    check_eq("zf_hold", 32'(zeroFlag), 32'd1);

    // Stall with a pending ADD and a competing counter update.
    op = 3'd0; set_lanes(16'h0101, 16'h0202); rw = 1'b1; uc = 1'b1; op2 = 16'd40;
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_rw", 32'(regWriteWB), 32'd0);
    end
    stop = 1'b0;
    cycle();
    check_eq("release_rw", 32'(regWriteWB), 32'd1);
    check_eq("release_cnt", 32'(resCount), 32'd41);
    rw = 1'b0; uc = 1'b0; mw = 1'b0;
    cycle();
    check_eq("post_rw", 32'(regWriteWB), 32'd0);

    // Random traffic including stalls.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); rd = 4'($urandom);
      rw = 1'($urandom); mw = 1'($urandom); uc = 1'($urandom);
      stop = ($urandom_range(0, 3) == 0);
      op1 = 16'($urandom_range(0, 3)); op2 = 16'($urandom_range(0, 3));
      for (int l = 0; l < 4; l++) begin
        la[l] = 16'($urandom); lb[l] = 16'($urandom);
      end
      cycle();
    end
    stop = 1'b0;

    // Asynchronous reset mid-stream discards the in-flight instruction.
    rw = 1'b1; mw = 1'b1; uc = 1'b1; op = 3'd4;
    set_lanes(16'h0F00, 16'h00F0); op1 = 16'd7; op2 = 16'd6; rd = 4'd9;
    cycle();
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    m = '0;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check_eq("post_reset_res", 32'(res1), 32'h0FF0);
    check_eq("post_reset_zf", 32'(zeroFlag), 32'd1);
    check_eq("post_reset_ret", 32'(retCount), 32'd1);

    // Counter wrap.
    op1 = 16'h0000; op2 = 16'hFFFF; uc = 1'b1; rw = 1'b0; mw = 1'b0;
    cycle();
    check_eq("wrap_cnt", 32'(resCount), 32'h0000);
    check_eq("wrap_zf", 32'(zeroFlag), 32'd1);

    // Retirement counter preload to FFFF, then wrap.
    uc = 1'b0; mw = 1'b1; op2 = 16'd0;
    while (m.ret != 16'hFFFF) cycle();
    check_eq("ret_full", 32'(retCount), 32'h0000FFFF);
    cycle();
    check_eq("ret_wrap", 32'(retCount), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
